// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage: a circular buffer of DEPTH control/data entries with valid/ready on both sides.
// Optional stall/flush statistics counters are built when PIPE_STAGE_BUFFER_STATS_EN is defined.
module pipe_stage_buffer #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 143,
  parameter int DEPTH  = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [CTRL_W-1:0]            InCtrl,
  input  logic [DATA_W-1:0]            InData,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [CTRL_W-1:0]            OutCtrl,
  output logic [DATA_W-1:0]            OutData,
  input  logic                         Flush,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
  output logic [31:0]                  StallCount,
  output logic [31:0]                  FlushCount
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

  logic [CTRL_W-1:0] ctrl_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic push, pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Handshake flags depend only on registered occupancy: no OutReady->InReady path.
  assign InReady   = (occ_q < FULL_C);
  assign OutValid  = (occ_q != '0);
  assign Occupancy = occ_q;
  assign push      = InValid && InReady;
  assign pop       = OutValid && OutReady;

  assign OutCtrl = OutValid ? ctrl_mem_q[head_q] : '0;
  assign OutData = OutValid ? data_mem_q[head_q] : '0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (Flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge Clk) begin
    if (push && !Flush) begin
      ctrl_mem_q[tail_q] <= InCtrl;
      data_mem_q[tail_q] <= InData;
    end
  end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (InValid && !InReady) stall_d = sat_inc(stall_q);
    if (Flush)               flush_d = sat_inc(flush_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: DEPTH=2 and DEPTH=3 instances share one stimulus stream
// and are each compared against a queue-based reference model after every clock edge.
module tb_pipe_stage_buffer;
  localparam int CW = 16;
  localparam int DW = 143;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          InValid = 1'b0;
  logic          OutReady = 1'b0;
  logic          Flush = 1'b0;
  logic [CW-1:0] InCtrl = '0;
  logic [DW-1:0] InData = '0;

  logic          ir2, ov2, ir3, ov3;
  logic [CW-1:0] oc2, oc3;
  logic [DW-1:0] od2, od3;
  logic [1:0]    occ2, occ3;
  logic [31:0]   sc2, fc2, sc3, fc3;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir2), .InCtrl(InCtrl), .InData(InData),
    .OutValid(ov2), .OutReady(OutReady), .OutCtrl(oc2), .OutData(od2), .Flush(Flush),
    .Occupancy(occ2), .StallCount(sc2), .FlushCount(fc2));

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u_d3 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir3), .InCtrl(InCtrl), .InData(InData),
    .OutValid(ov3), .OutReady(OutReady), .OutCtrl(oc3), .OutData(od3), .Flush(Flush),
    .Occupancy(occ3), .StallCount(sc3), .FlushCount(fc3));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q2[$];
  ent_t q3[$];
  int   st2, st3, fl;
  int   tests, fails;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h2, h3;
    logic [31:0] es2, es3, ef;
    h2 = (q2.size() != 0) ? q2[0] : '0;
    h3 = (q3.size() != 0) ? q3[0] : '0;
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    es2 = 32'(st2); es3 = 32'(st3); ef = 32'(fl);
`else
    es2 = '0; es3 = '0; ef = '0;
`endif
    chk("d2_outvalid",  DW'(ov2),  DW'(q2.size() != 0));
    chk("d2_inready",   DW'(ir2),  DW'(q2.size() < 2));
    chk("d2_occupancy", DW'(occ2), DW'(q2.size()));
    chk("d2_outctrl",   DW'(oc2),  DW'(h2.c));
    chk("d2_outdata",   od2,       h2.d);
    chk("d2_stallcnt",  DW'(sc2),  DW'(es2));
    chk("d2_flushcnt",  DW'(fc2),  DW'(ef));
    chk("d3_outvalid",  DW'(ov3),  DW'(q3.size() != 0));
    chk("d3_inready",   DW'(ir3),  DW'(q3.size() < 3));
    chk("d3_occupancy", DW'(occ3), DW'(q3.size()));
    chk("d3_outctrl",   DW'(oc3),  DW'(h3.c));
    chk("d3_outdata",   od3,       h3.d);
    chk("d3_stallcnt",  DW'(sc3),  DW'(es3));
    chk("d3_flushcnt",  DW'(fc3),  DW'(ef));
  endtask

  // Drive one cycle of inputs, advance the reference queues at the edge, then compare.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic f);
    logic pu2, po2, pu3, po3;
    InValid = v; InCtrl = c; InData = d; OutReady = r; Flush = f;
    @(posedge Clk);
    pu2 = v && (q2.size() < 2);
    po2 = r && (q2.size() != 0);
    pu3 = v && (q3.size() < 3);
    po3 = r && (q3.size() != 0);
    if (v && !pu2) st2++;
    if (v && !pu3) st3++;
    if (f) begin
      fl++;
      q2.delete();
      q3.delete();
    end else begin
      if (po2) void'(q2.pop_front());
      if (pu2) q2.push_back({c, d});
      if (po3) void'(q3.pop_front());
      if (pu3) q3.push_back({c, d});
    end
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] dA, dB, dC, dD;
    tests = 0; fails = 0; st2 = 0; st3 = 0; fl = 0;

    // Reset state, observed while reset is held.
    #1;
    check_all();
    chk("reset_inready", DW'(ir2), DW'(1'b1));
    @(negedge Clk);
    Reset = 1'b1;

    // Single entry: one-cycle latency, then a bubble.
    step(1'b1, 16'h0041, DW'(143'h1234), 1'b1, 1'b0);
    chk("single_ctrl", DW'(oc2), DW'(16'h0041));
    chk("single_data", od2, DW'(143'h1234));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bubble_ctrl", DW'(oc2), '0);

    // Fill while downstream stalls; C is held off by the full DEPTH=2 stage.
    dA = rnd_data(); dB = rnd_data(); dC = rnd_data();
    step(1'b1, 16'h00A1, dA, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, dB, 1'b0, 1'b0);
    step(1'b1, 16'h00C3, dC, 1'b0, 1'b0);
    chk("full_inready", DW'(ir2), DW'(1'b0));
    step(1'b1, 16'h00C3, dC, 1'b0, 1'b0);
    step(1'b1, 16'h00C3, dC, 1'b1, 1'b0);
    step(1'b1, 16'h00C3, dC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming push/pop: DEPTH=3 pointers wrap while occupancy stays at 1.
    for (int i = 0; i < 10; i++) step(1'b1, CW'($urandom), rnd_data(), 1'b1, 1'b0);
    chk("stream_occ3", DW'(occ3), DW'(2'd1));
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush coincident with a push of D.
    step(1'b1, 16'h0011, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 16'h0022, rnd_data(), 1'b0, 1'b0);
    dD = rnd_data();
    step(1'b1, 16'h00DD, dD, 1'b1, 1'b1);
    chk("flush_occ2", DW'(occ2), '0);
    chk("flush_occ3", DW'(occ3), '0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 16'h0033, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 16'h0044, rnd_data(), 1'b0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    q2.delete(); q3.delete(); st2 = 0; st3 = 0; fl = 0;
    chk("async_rst_outvalid", DW'(ov2), DW'(1'b0));
    chk("async_rst_inready",  DW'(ir2), DW'(1'b1));
    check_all();
    @(negedge Clk);
    Reset = 1'b1;

    // Full-stall cycles followed by two flushes.
    step(1'b1, 16'h0055, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 16'h0066, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0077, rnd_data(), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), CW'($urandom), rnd_data(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
